datamem_lsu: RTL and testbench

DATAMEM_LSU -- requirements
Module: datamem_lsu

---
 rtl/datamem_lsu.sv | 143 ++++++++++++++
 tb/tb_datamem_lsu.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/datamem_lsu.sv
// Byte-addressable data memory with a load/store front end.
// Accepts one RISC-V style load or store at a time; loads take one extra cycle for the synchronous read.
module datamem_lsu #(
    parameter int DM_ADDRESS = 12,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err
);

    localparam int L    = DATA_W / 8;
    localparam int LB   = $clog2(L);
    localparam int ROWS = 2 ** (DM_ADDRESS - LB);

    typedef enum logic [1:0] {IDLE, RD, RESP} state_t;

    state_t state, state_nx;

    logic [DATA_W-1:0]        mem [ROWS];
    logic [DM_ADDRESS-LB-1:0] row;
    logic [LB-1:0]            off;
    logic                     legal_f3;
    logic                     misaligned;
    logic                     fault;
    logic                     accept;
    logic [L-1:0]             be_base;
    logic [L-1:0]             be;
    logic [DATA_W-1:0]        wshift;

    logic [DATA_W-1:0]        rd_row;
    logic [LB-1:0]            off_q;
    logic [2:0]               f3_q;
    logic [DATA_W-1:0]        shifted;
    logic [DATA_W-1:0]        mask;
    logic                     sign;
    logic [DATA_W-1:0]        load_ext;

    assign row        = req_addr[DM_ADDRESS-1:LB];
    assign off        = req_addr[LB-1:0];
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && (state == IDLE);

    always_comb begin
        legal_f3   = 1'b0;
        misaligned = 1'b0;
        if (req_we) begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
                3'b011:                 legal_f3 = (DATA_W == 64);
                default:                legal_f3 = 1'b0;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_f3 = 1'b1;
                3'b011, 3'b110:                         legal_f3 = (DATA_W == 64);
                default:                                legal_f3 = 1'b0;
            endcase
        end
        case (req_funct3[1:0])
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            2'd3:    misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
        fault = !legal_f3 || misaligned;
    end

    always_comb begin
        case (req_funct3[1:0])
            2'd0:    be_base = L'(1);
            2'd1:    be_base = L'(3);
            2'd2:    be_base = L'(15);
            default: be_base = '1;
        endcase
        be     = be_base << off;
        wshift = req_wdata << {off, 3'b000};
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = (fault || req_we) ? RESP : RD;
            RD:      state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Memory is never reset; reset only blocks the write that would coincide with it.
    always_ff @(posedge clk) begin
        if (!reset && accept && !fault && req_we) begin
            for (int unsigned i = 0; i < L; i++) begin
                if (be[i]) mem[row][8*i +: 8] <= wshift[8*i +: 8];
            end
        end
        if (accept && !fault && !req_we) begin
            rd_row <= mem[row];
            off_q  <= off;
            f3_q   <= req_funct3;
        end
    end

    always_comb begin
        shifted = rd_row >> {off_q, 3'b000};
        mask    = '0;
        case (f3_q[1:0])
            2'd0: begin mask[7:0]  = '1; sign = shifted[7];  end
            2'd1: begin mask[15:0] = '1; sign = shifted[15]; end
            2'd2: begin mask[31:0] = '1; sign = shifted[31]; end
            default: begin mask = '1; sign = shifted[DATA_W-1]; end
        endcase
        load_ext = (shifted & mask) | ((!f3_q[2] && sign) ? ~mask : '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (accept && (fault || req_we)) begin
            resp_rdata <= '0;
            resp_err   <= fault;
        end else if (state == RD) begin
            resp_rdata <= load_ext;
            resp_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_datamem_lsu.sv
// Directed scoreboard bench for datamem_lsu (default 32-bit data, 12-bit addresses).
module tb_datamem_lsu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [11:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    datamem_lsu #(.DM_ADDRESS(12), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
        string       name;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resp_valid) begin
            if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp at cycle %0d: rdata %h err %b expected no response",
                         cyc, resp_rdata, resp_err);
            end else begin
                e = sbq.pop_front();
                check({e.name, "_rdata"}, resp_rdata, e.rdata);
                check({e.name, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
                check({e.name, "_cycle"}, cyc, e.due);
            end
        end
    end

    task automatic issue(input string nm, input logic we, input logic [2:0] f3,
                         input logic [11:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err);
        int n;
        int lat;
        lat = (we || exp_err) ? 1 : 2;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_ready_timeout: req_ready %b expected 1", nm, req_ready);
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        sbq.push_back('{exp_rdata, exp_err, cyc + lat, nm});
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        while (sbq.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_resp_timeout: %0d responses outstanding expected 0", nm, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic check_quiet(input string nm);
        check({nm, "_ready"}, {31'd0, req_ready}, 32'd1);
        check({nm, "_valid"}, {31'd0, resp_valid}, 32'd0);
        check({nm, "_rdata"}, resp_rdata, 32'd0);
        check({nm, "_err"}, {31'd0, resp_err}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_quiet("reset");

        issue("sw_100", 1'b1, 3'b010, 12'h100, 32'hDEADBEEF, 32'h0, 1'b0);
        issue("lw_100_a", 1'b0, 3'b010, 12'h100, 32'h0, 32'hDEADBEEF, 1'b0);
        repeat (2) @(negedge clk);
        check("hold_rdata", resp_rdata, 32'hDEADBEEF);

        issue("sb_101", 1'b1, 3'b000, 12'h101, 32'h00000080, 32'h0, 1'b0);
        issue("lb_101", 1'b0, 3'b000, 12'h101, 32'h0, 32'hFFFFFF80, 1'b0);
        issue("lbu_101", 1'b0, 3'b100, 12'h101, 32'h0, 32'h00000080, 1'b0);
        issue("lw_100_b", 1'b0, 3'b010, 12'h100, 32'h0, 32'hDEAD80EF, 1'b0);

        issue("sh_102", 1'b1, 3'b001, 12'h102, 32'h00007FFF, 32'h0, 1'b0);
        issue("lh_102", 1'b0, 3'b001, 12'h102, 32'h0, 32'h00007FFF, 1'b0);
        issue("lhu_100", 1'b0, 3'b101, 12'h100, 32'h0, 32'h000080EF, 1'b0);

        issue("lw_102_mis", 1'b0, 3'b010, 12'h102, 32'h0, 32'h0, 1'b1);
        issue("sh_103_mis", 1'b1, 3'b001, 12'h103, 32'h0000FFFF, 32'h0, 1'b1);
        issue("lh_101_mis", 1'b0, 3'b001, 12'h101, 32'h0, 32'h0, 1'b1);
        issue("lw_100_c", 1'b0, 3'b010, 12'h100, 32'h0, 32'h7FFF80EF, 1'b0);

        issue("ld_f3_111", 1'b0, 3'b111, 12'h100, 32'h0, 32'h0, 1'b1);
        issue("ld_f3_011", 1'b0, 3'b011, 12'h100, 32'h0, 32'h0, 1'b1);
        issue("ld_f3_110", 1'b0, 3'b110, 12'h100, 32'h0, 32'h0, 1'b1);
        issue("st_f3_100", 1'b1, 3'b100, 12'h100, 32'h12345678, 32'h0, 1'b1);
        issue("st_f3_011", 1'b1, 3'b011, 12'h100, 32'h12345678, 32'h0, 1'b1);
        issue("lw_100_d", 1'b0, 3'b010, 12'h100, 32'h0, 32'h7FFF80EF, 1'b0);

        issue("sw_ffc", 1'b1, 3'b010, 12'hFFC, 32'h11223344, 32'h0, 1'b0);
        issue("sb_fff", 1'b1, 3'b000, 12'hFFF, 32'h000000A5, 32'h0, 1'b0);
        issue("lw_ffc", 1'b0, 3'b010, 12'hFFC, 32'h0, 32'hA5223344, 1'b0);
        issue("lh_ffe", 1'b0, 3'b001, 12'hFFE, 32'h0, 32'hFFFFA522, 1'b0);
        issue("lbu_fff", 1'b0, 3'b100, 12'hFFF, 32'h0, 32'h000000A5, 1'b0);
        issue("sw_000", 1'b1, 3'b010, 12'h000, 32'h01020304, 32'h0, 1'b0);
        issue("lb_003", 1'b0, 3'b000, 12'h003, 32'h0, 32'h00000001, 1'b0);
        issue("lhu_000", 1'b0, 3'b101, 12'h000, 32'h0, 32'h00000304, 1'b0);

        // Hold a store request on the bus while a load is in RD/RESP; it must be ignored.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 12'h100;
        sbq.push_back('{32'h7FFF80EF, 1'b0, cyc + 2, "lw_busy"});
        @(posedge clk);
        #1;
        req_we    = 1'b1;
        req_wdata = 32'h0BADF00D;
        check("busy_ready", {31'd0, req_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1 req_valid = 1'b0;
        issue("lw_after_busy", 1'b0, 3'b010, 12'h100, 32'h0, 32'h7FFF80EF, 1'b0);

        // Reset while a load sits in RD.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 12'h100;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset     = 1'b1;
        check("rd_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        check_quiet("abort_rd");
        repeat (4) @(posedge clk);

        // Store presented on a reset edge must not write.
        @(negedge clk);
        reset      = 1'b1;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 12'h100;
        req_wdata  = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        req_valid = 1'b0;
        check_quiet("reset_store");
        issue("lw_after_rst_st", 1'b0, 3'b010, 12'h100, 32'h0, 32'h7FFF80EF, 1'b0);

        issue("sw_200", 1'b1, 3'b010, 12'h200, 32'h55AA55AA, 32'h0, 1'b0);
        issue("lw_200", 1'b0, 3'b010, 12'h200, 32'h0, 32'h55AA55AA, 1'b0);

        repeat (4) @(posedge clk);
        check("sbq_empty", sbq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
